// File: rtl/mem_port.sv
// ----------------------------------------------------------------------------
// mem_port: aligned load/store port driving a valid/ready 64-bit memory bus.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        phi1,
  input  logic        rst_n,
  input  logic        read_rq,
  input  logic        write_rq,
  input  logic [55:0] addr,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [55:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        bus_we_q, bus_we_d;
  logic [55:0] bus_addr_q, bus_addr_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  bus_wstrb_q, bus_wstrb_d;
  logic [2:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;

  logic        w_rq;
  logic        w_misaligned;
  logic [7:0]  w_strb_base;
  logic [63:0] w_rd_shift;
  logic [63:0] w_rd_mask;

  assign w_rq = read_rq | write_rq;

  always_comb begin
    w_misaligned = 1'b0;
    w_strb_base  = 8'h01;
    case (size)
      2'd0: begin w_misaligned = 1'b0;          w_strb_base = 8'h01; end
      2'd1: begin w_misaligned = addr[0];       w_strb_base = 8'h03; end
      2'd2: begin w_misaligned = |addr[1:0];    w_strb_base = 8'h0F; end
      default: begin w_misaligned = |addr[2:0]; w_strb_base = 8'hFF; end
    endcase
  end

  // Load data is taken from the lane captured at request time, not the live address.
  assign w_rd_shift = bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    w_rd_mask = 64'h0000_0000_0000_00FF;
      2'd1:    w_rd_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_rd_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    lane_d       = lane_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    stall        = 1'b0;
    access_fault = 1'b0;
    bus_valid    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = w_rq;
        if (w_rq) begin
          if (w_misaligned) begin
            state_d = S_FAULT;
          end else begin
            state_d     = S_REQ;
            bus_we_d    = write_rq;
            bus_addr_d  = {addr[55:3], 3'b000};
            bus_wdata_d = wdata << {addr[2:0], 3'b000};
            bus_wstrb_d = write_rq ? (w_strb_base << addr[2:0]) : 8'h00;
            lane_d      = addr[2:0];
            size_d      = size;
            cnt_d       = 8'd0;
          end
        end
      end
      S_REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (bus_ready) begin
          if (bus_err) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_DONE;
            if (!bus_we_q) rdata_d = w_rd_shift & w_rd_mask;
          end
        end else if (cnt_q == c_cnt_last) begin
          state_d = S_FAULT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        access_fault = 1'b1;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge phi1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 56'd0;
      bus_wdata_q <= 64'd0;
      bus_wstrb_q <= 8'd0;
      lane_q      <= 3'd0;
      size_q      <= 2'd0;
      cnt_q       <= 8'd0;
      rdata_q     <= 64'd0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

`default_nettype wire
